ram1p1rwbe_init: RTL and testbench

Parametrised single-port read/write RAM with byte write enables and a built-in post-reset initialisation sequencer. It generalises the fixed 64x128 SRAM macro wrapper to arbitrary depth and width, with an optional output pipeline register. Caches and scratchpads use it wherever contents must be in a known state after reset without a software clear loop. The behavioural array stands in for vendor macros in simulation and FPGA builds.

---
 rtl/ram1p1rwbe_init.sv | 130 +++++++++++++
 tb/tb_ram1p1rwbe_init.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram1p1rwbe_init.sv
// rtl/ram1p1rwbe_init.sv - single-port byte-writable RAM with post-reset init sweep
module ram1p1rwbe_init #(
    parameter int               DEPTH    = 64,
    parameter int               WIDTH    = 128,
    parameter int               OUTREG   = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    input  logic [WIDTH/8-1:0]       bwe,
    output logic [WIDTH-1:0]         dout,
    output logic                     dvalid,
    output logic                     ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    generate
        if ((WIDTH % 8) != 0 || DEPTH < 2) begin : g_bad_params
            $error("ram1p1rwbe_init: WIDTH must be a multiple of 8 and DEPTH >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             pipe_valid_q, pipe_valid_d;
    logic [WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic             dvalid_q, dvalid_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             in_range;
    logic             rd_fire;
    logic [WIDTH-1:0] rd_word;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [NB-1:0]    wr_be;
    logic             fin_valid;
    logic [WIDTH-1:0] fin_data;

    // Address decode: out-of-range words read as zero and cannot be written.
    always_comb begin
        in_range = 32'(addr) < 32'(DEPTH);
        rd_word  = in_range ? mem[addr] : '0;
    end

    // Sequencer: the init sweep owns the array port until the last word is written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = din;
        wr_be   = bwe;
        rd_fire = 1'b0;
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = INIT_VAL;
            wr_be   = '1;
            cnt_d   = cnt_q + AW'(1);
            if (32'(cnt_q) == 32'(DEPTH - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            wr_en   = ce && we && in_range;
            rd_fire = ce && !we;
        end
    end

    // Read return path: optional extra stage, then dout holds until the next completion.
    always_comb begin
        pipe_valid_d = rd_fire;
        pipe_data_d  = rd_fire ? rd_word : pipe_data_q;
        if (OUTREG != 0) begin
            fin_valid = pipe_valid_q;
            fin_data  = pipe_data_q;
        end else begin
            fin_valid = rd_fire;
            fin_data  = rd_word;
        end
        dvalid_d = fin_valid;
        dout_d   = fin_valid ? fin_data : dout_q;
    end

    // Control and output registers; reset drops any read still in the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            dvalid_q     <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            dvalid_q     <= dvalid_d;
            dout_q       <= dout_d;
        end
    end

    // Array write with per-byte enables; contents survive reset untouched.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign ready  = (state_q == ST_RUN);

endmodule

// File: tb/tb_ram1p1rwbe_init.sv
// tb/tb_ram1p1rwbe_init.sv - self-checking bench for ram1p1rwbe_init
module tb_ram1p1rwbe_init;

    localparam logic [31:0] INIT_B = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: DEPTH 64, WIDTH 128, OUTREG 1, INIT_VAL 0
    logic         reset_a, ce_a, we_a;
    logic [5:0]   addr_a;
    logic [127:0] din_a, dout_a;
    logic [15:0]  bwe_a;
    logic         dvalid_a, ready_a;

    // Instance B: DEPTH 48, WIDTH 32, OUTREG 0, nonzero INIT_VAL
    logic         reset_b, ce_b, we_b;
    logic [5:0]   addr_b;
    logic [31:0]  din_b, dout_b;
    logic [3:0]   bwe_b;
    logic         dvalid_b, ready_b;

    ram1p1rwbe_init #(.DEPTH(64), .WIDTH(128), .OUTREG(1), .INIT_VAL(128'h0)) u_dut_a (
        .clk(clk), .reset(reset_a), .ce(ce_a), .we(we_a), .addr(addr_a), .din(din_a),
        .bwe(bwe_a), .dout(dout_a), .dvalid(dvalid_a), .ready(ready_a)
    );

    ram1p1rwbe_init #(.DEPTH(48), .WIDTH(32), .OUTREG(0), .INIT_VAL(INIT_B)) u_dut_b (
        .clk(clk), .reset(reset_b), .ce(ce_b), .we(we_b), .addr(addr_b), .din(din_b),
        .bwe(bwe_b), .dout(dout_b), .dvalid(dvalid_b), .ready(ready_b)
    );

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    typedef struct {
        logic         we;
        logic [5:0]   addr;
        logic [127:0] din;
        logic [15:0]  bwe;
        logic [127:0] exp;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    vec_t va[18];
    vec_t vb[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [5:0] a, input logic [127:0] d,
                                input logic [15:0] be, input logic [127:0] e);
        vec_t v;
        v.we   = w;
        v.addr = a;
        v.din  = d;
        v.bwe  = be;
        v.exp  = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_a(input vec_t v);
        ce_a   = 1'b1;
        we_a   = v.we;
        addr_a = v.addr;
        din_a  = v.din;
        bwe_a  = v.bwe;
        if (!v.we) qa.push_back('{data: v.exp, due: cyc + 2});
        tick();
    endtask

    task automatic apply_b(input vec_t v);
        ce_b   = 1'b1;
        we_b   = v.we;
        addr_b = v.addr;
        din_b  = v.din[31:0];
        bwe_b  = v.bwe[3:0];
        if (!v.we) qb.push_back('{data: v.exp, due: cyc + 1});
        tick();
    endtask

    task automatic drain(input bit is_b);
        ce_a = 1'b0;
        ce_b = 1'b0;
        for (int k = 0; k < 8 && (is_b ? qb.size() : qa.size()) != 0; k++) tick();
        check(is_b ? "b_drain" : "a_drain", is_b ? qb.size() : qa.size(), 0);
    endtask

    // Called in cycle 0 after reset deassertion; ready must rise exactly at cycle n.
    task automatic sweep_check(input bit is_b, input int n);
        for (int i = 0; i <= n; i++) begin
            if (i == n) begin
                ce_a = 1'b0;
                ce_b = 1'b0;
            end
            @(negedge clk);
            check(is_b ? "b_init_ready" : "a_init_ready", is_b ? ready_b : ready_a, 128'(i == n));
            tick();
        end
    endtask

    // Scoreboards: every dvalid must match the oldest outstanding read, on its due cycle.
    always @(negedge clk) begin
        if (dvalid_a === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_dvalid", dvalid_a, 0);
            end else begin
                ea = qa.pop_front();
                check("a_rd_data", dout_a, ea.data);
                check("a_rd_latency", 128'(cyc), 128'(ea.due));
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            ea = qa.pop_front();
            check("a_missing_dvalid", dvalid_a, 1);
        end
        if (dvalid_b === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_dvalid", dvalid_b, 0);
            end else begin
                eb = qb.pop_front();
                check("b_rd_data", 128'(dout_b), eb.data);
                check("b_rd_latency", 128'(cyc), 128'(eb.due));
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            eb = qb.pop_front();
            check("b_missing_dvalid", dvalid_b, 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got %0d compared, expected completion", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        va[0]  = mk(1, 5, {16{8'hFF}}, 16'h0001, '0);
        va[1]  = mk(0, 5, '0, '0, 128'hFF);
        va[2]  = mk(1, 5, {16{8'hAA}}, 16'h8000, '0);
        va[3]  = mk(0, 5, '0, '0, {8'hAA, 112'h0, 8'hFF});
        va[4]  = mk(1, 1, {16{8'h11}}, 16'hFFFF, '0);
        va[5]  = mk(1, 2, {16{8'h22}}, 16'hFFFF, '0);
        va[6]  = mk(1, 3, {16{8'h33}}, 16'hFFFF, '0);
        va[7]  = mk(0, 1, '0, '0, {16{8'h11}});
        va[8]  = mk(0, 2, '0, '0, {16{8'h22}});
        va[9]  = mk(0, 3, '0, '0, {16{8'h33}});
        va[10] = mk(1, 7, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF, '0);
        va[11] = mk(0, 7, '0, '0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        va[12] = mk(1, 7, '1, 16'h0000, '0);
        va[13] = mk(0, 7, '0, '0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        va[14] = mk(1, 7, '1, 16'h00F0, '0);
        va[15] = mk(0, 63, '0, '0, '0);
        va[16] = mk(0, 0, '0, '0, '0);
        va[17] = mk(0, 7, '0, '0, 128'h0123_4567_89AB_CDEF_FFFF_FFFF_7654_3210);

        vb[0]  = mk(1, 50, 128'hFFFF_FFFF, 16'hF, '0);
        vb[1]  = mk(0, 50, '0, '0, '0);
        vb[2]  = mk(0, 2, '0, '0, 128'(INIT_B));
        vb[3]  = mk(0, 47, '0, '0, 128'(INIT_B));
        vb[4]  = mk(1, 47, 128'h1234_5678, 16'h5, '0);
        vb[5]  = mk(0, 47, '0, '0, 128'hA534_5A78);
        vb[6]  = mk(0, 1, '0, '0, 128'(INIT_B));
        vb[7]  = mk(0, 3, '0, '0, 128'(INIT_B));
        vb[8]  = mk(1, 10, 128'hCAFE_F00D, 16'hF, '0);
        vb[9]  = mk(0, 10, '0, '0, 128'hCAFE_F00D);
        vb[10] = mk(0, 50, '0, '0, '0);

        reset_a = 1'b1; ce_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0; bwe_a = '0;
        reset_b = 1'b1; ce_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0; bwe_b = '0;

        repeat (2) tick();
        @(negedge clk);
        check("a_reset_ready", ready_a, 0);
        check("a_reset_dvalid", dvalid_a, 0);
        check("a_reset_dout", dout_a, 0);
        check("b_reset_ready", ready_b, 0);
        check("b_reset_dout", 128'(dout_b), 0);
        tick();

        // A: init sweep with write requests hammering addr 3 (must be ignored)
        ce_a = 1'b1; we_a = 1'b1; addr_a = 6'd3; din_a = '1; bwe_a = '1;
        reset_a = 1'b0;
        sweep_check(0, 64);

        for (int a = 0; a < 64; a++) apply_a(mk(0, 6'(a), '0, '0, '0));
        drain(0);

        for (int i = 0; i < 18; i++) apply_a(va[i]);
        drain(0);
        repeat (3) tick();
        @(negedge clk);
        check("a_dout_hold", dout_a, va[17].exp);
        check("a_idle_dvalid", dvalid_a, 0);
        tick();

        // A: reset pulse 30 cycles into the sweep restarts it
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("a_midinit_ready", ready_a, 0);
            tick();
        end
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        sweep_check(0, 64);

        // A: reset with a read in flight discards it and clears dout
        apply_a(mk(1, 9, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 16'hFFFF, '0));
        apply_a(mk(0, 9, '0, '0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555));
        drain(0);
        ce_a = 1'b1; we_a = 1'b0; addr_a = 6'd9;
        tick();
        ce_a = 1'b0;
        reset_a = 1'b1;
        tick();
        @(negedge clk);
        check("a_flight_dvalid", dvalid_a, 0);
        check("a_flight_dout", dout_a, 0);
        reset_a = 1'b0;
        tick();
        @(negedge clk);
        check("a_flight_dvalid_late", dvalid_a, 0);
        tick();

        // B: non-power-of-two depth, OUTREG 0
        reset_b = 1'b0;
        sweep_check(1, 48);
        for (int i = 0; i < 11; i++) apply_b(vb[i]);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
